// File: rtl/sync_fifo_param.sv
// sync_fifo_param: FWFT synchronous FIFO, circular buffer with wrap-bit pointers; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags
module sync_fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic push, pop;
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);
  assign push         = wr_en & ~full;
  assign pop          = rd_en & ~empty;
  assign data_out     = mem_q[rd_ptr_q[AW-1:0]];
  // Pointer advance; the wrap bit toggles naturally on index overflow
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end
  // Pointer registers; async clear discards all stored words
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Storage array, intentionally not reset
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  // Sticky error flags; a new error in the same cycle beats clr_err
  always_comb begin
    overflow_d  = (wr_en & full)  | (overflow_q  & ~clr_err);
    underflow_d = (rd_en & empty) | (underflow_q & ~clr_err);
  end
  // Error flag registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table vectors, corner sequences and random traffic against a queue model
module tb_sync_fifo_param;
  localparam int D = 8;
  logic clock = 1'b0, resetn, wr_en, rd_en;
  logic [31:0] data_in, data_out;
  logic full, empty, almost_full, almost_empty;
  logic [3:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic clr_err, overflow, underflow;
`endif
  int n_pass = 0, n_total = 0;
  logic [31:0] q[$];
  logic m_ov = 1'b0, m_uf = 1'b0;
  typedef struct {
    logic wr, rd;
    logic [31:0] din;
    int cnt;
    logic [31:0] dout;
    logic e, f, af, ae;
  } vec_t;
  vec_t tbl[18];

  always #5 clock = ~clock;

  sync_fifo_param #(.WIDTH(32), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clock(clock), .resetn(resetn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] d, input logic c);
    int pre;
    wr_en = w; rd_en = r; data_in = d;
`ifdef FIFO_ERR_FLAGS_EN
    clr_err = c;
`endif
    @(posedge clock);
    pre = q.size();
    if (r && pre > 0) void'(q.pop_front());
    if (w && pre < D) q.push_back(d);
    m_ov = (w && pre == D) || (m_ov && !c);
    m_uf = (r && pre == 0) || (m_uf && !c);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    clr_err = 1'b0;
`endif
  endtask

  task automatic check_model(input string nm);
    int n;
    n = q.size();
    chk({nm, ".count"}, 32'(count), 32'(n));
    chk({nm, ".empty"}, 32'(empty), 32'(n == 0));
    chk({nm, ".full"}, 32'(full), 32'(n == D));
    chk({nm, ".af"}, 32'(almost_full), 32'(n >= 6));
    chk({nm, ".ae"}, 32'(almost_empty), 32'(n <= 2));
    if (n > 0) chk({nm, ".dout"}, data_out, q[0]);
`ifdef FIFO_ERR_FLAGS_EN
    chk({nm, ".ovf"}, 32'(overflow), 32'(m_ov));
    chk({nm, ".udf"}, 32'(underflow), 32'(m_uf));
`endif
  endtask

  task automatic areset();
    resetn = 1'b0;
    q.delete(); m_ov = 1'b0; m_uf = 1'b0;
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.empty", 32'(empty), 1);
    chk("arst.ae", 32'(almost_empty), 1);
    chk("arst.full", 32'(full), 0);
    chk("arst.af", 32'(almost_full), 0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
`ifdef FIFO_ERR_FLAGS_EN
    clr_err = 1'b0;
`endif
    for (int i = 0; i < 8; i++) tbl[i] = '{1, 0, 32'hA0 + i, i + 1, 32'hA0, 0, i == 7, i >= 5, i <= 1};
    tbl[8] = '{1, 0, 32'hFF, 8, 32'hA0, 0, 1, 1, 0};
    for (int j = 0; j < 8; j++) tbl[9 + j] = '{0, 1, 0, 7 - j, 32'hA1 + j, j == 7, 0, 7 - j >= 6, 7 - j <= 2};
    tbl[17] = '{0, 1, 0, 0, 0, 1, 0, 0, 1};
    repeat (2) @(posedge clock);
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.ae", 32'(almost_empty), 1);
    chk("rst.af", 32'(almost_full), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.udf", 32'(underflow), 0);
`endif
    @(negedge clock);
    resetn = 1'b1;
    // fill, overflow, drain, extra pop
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din, 1'b0);
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].e));
      chk($sformatf("tbl%0d.full", i), 32'(full), 32'(tbl[i].f));
      chk($sformatf("tbl%0d.af", i), 32'(almost_full), 32'(tbl[i].af));
      chk($sformatf("tbl%0d.ae", i), 32'(almost_empty), 32'(tbl[i].ae));
      if (!tbl[i].e) chk($sformatf("tbl%0d.dout", i), data_out, tbl[i].dout);
`ifdef FIFO_ERR_FLAGS_EN
      if (i == 8) chk("tbl.ovf_set", 32'(overflow), 1);
      if (i == 17) chk("tbl.udf_set", 32'(underflow), 1);
`endif
    end
`ifdef FIFO_ERR_FLAGS_EN
    step(1'b0, 1'b0, 0, 1'b1);
    chk("clr.ovf", 32'(overflow), 0);
    chk("clr.udf", 32'(underflow), 0);
`endif
    check_model("post_tbl");
    // async reset mid-traffic at count=5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h50 + i, 1'b0);
    chk("pre_rst.count", 32'(count), 5);
    areset();
    // simultaneous push+pop at count=3 across two wraps
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h100 + k, 1'b0);
    for (int k = 3; k < 23; k++) begin
      step(1'b1, 1'b1, 32'h100 + k, 1'b0);
      chk("sim.count", 32'(count), 3);
      chk("sim.dout", data_out, 32'h100 + k - 2);
    end
    check_model("sim");
    // push+pop on empty, then push+pop on full
    areset();
    step(1'b1, 1'b1, 32'hC0DE, 1'b0);
    chk("pp_empty.count", 32'(count), 1);
    chk("pp_empty.dout", data_out, 32'hC0DE);
    check_model("pp_empty");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'hD0 + i, 1'b0);
    chk("pp_full.pre", 32'(full), 1);
    step(1'b1, 1'b1, 32'hEE, 1'b0);
    chk("pp_full.count", 32'(count), 7);
    chk("pp_full.dout", data_out, 32'hD0);
    check_model("pp_full");
    // randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      int p;
      p = ((i / 60) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < p, $urandom_range(0, 99) < 100 - p, $urandom, $urandom_range(0, 15) == 0);
      check_model("rnd");
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
